// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: aligned dword memory port, byte-lane RMW stores.
// Ports: req_* request in, resp_* completion out, dm_* data memory port.
module mem_access_unit #(
  parameter int ADDR_LIMIT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        req_ready,
  output logic        stall,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] dm_address,
  output logic [63:0] dm_write_data,
  output logic        dm_write,
  output logic        dm_read,
  input  logic [63:0] dm_read_data
);

  typedef enum logic [2:0] {
    IDLE, LOAD, RMW_READ, WRITE, RESP
  } state_t;

  localparam logic [64:0] LIM = 65'(ADDR_LIMIT);

  state_t      state_q, state_d;
  logic [63:0] aligned_q, aligned_d;
  logic [2:0]  off_q, off_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        write_q, write_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] merged_q, merged_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        mis_bad, rng_bad, f3_bad;
  logic [7:0]  size_mask, byte_en;
  logic [63:0] bit_mask, wsh, ld_sh, ld_ext;

  always_comb begin
    mis_bad = 1'b0;
    unique case (req_funct3[1:0])
      2'd0: mis_bad = 1'b0;
      2'd1: mis_bad = req_addr[0];
      2'd2: mis_bad = |req_addr[1:0];
      2'd3: mis_bad = |req_addr[2:0];
      default: mis_bad = 1'b1;
    endcase
    // 65-bit sum so addresses near 2^64 cannot wrap into range
    rng_bad = ({1'b0, req_addr[63:3], 3'b000} + 65'd8) > LIM;
    f3_bad  = req_write ? req_funct3[2]
                        : (req_funct3 == 3'b111);
  end

  always_comb begin
    size_mask = 8'h00;
    unique case (funct3_q[1:0])
      2'd0: size_mask = 8'h01;
      2'd1: size_mask = 8'h03;
      2'd2: size_mask = 8'h0F;
      2'd3: size_mask = 8'hFF;
      default: size_mask = 8'h00;
    endcase
    byte_en = size_mask << off_q;
    bit_mask = '0;
    for (int i = 0; i < 8; i++)
      bit_mask[8*i +: 8] = {8{byte_en[i]}};
    wsh   = wdata_q << {off_q, 3'b000};
    ld_sh = dm_read_data >> {off_q, 3'b000};
    ld_ext = ld_sh;
    unique case (funct3_q)
      3'b000: ld_ext = {{56{ld_sh[7]}}, ld_sh[7:0]};
      3'b001: ld_ext = {{48{ld_sh[15]}}, ld_sh[15:0]};
      3'b010: ld_ext = {{32{ld_sh[31]}}, ld_sh[31:0]};
      3'b100: ld_ext = {56'd0, ld_sh[7:0]};
      3'b101: ld_ext = {48'd0, ld_sh[15:0]};
      3'b110: ld_ext = {32'd0, ld_sh[31:0]};
      default: ld_ext = ld_sh;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    aligned_d     = aligned_q;
    off_d         = off_q;
    funct3_d      = funct3_q;
    write_d       = write_q;
    wdata_d       = wdata_q;
    merged_d      = merged_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    dm_read       = 1'b0;
    dm_write      = 1'b0;
    dm_address    = '0;
    dm_write_data = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          aligned_d = {req_addr[63:3], 3'b000};
          off_d     = req_addr[2:0];
          funct3_d  = req_funct3;
          write_d   = req_write;
          wdata_d   = req_wdata;
          if (mis_bad || rng_bad || f3_bad) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end else if (!req_write) begin
            state_d = LOAD;
          end else if (req_funct3[1:0] == 2'd3) begin
            merged_d = req_wdata;
            state_d  = WRITE;
          end else begin
            state_d = RMW_READ;
          end
        end
      end
      LOAD: begin
        dm_read    = 1'b1;
        dm_address = aligned_q;
        rdata_d    = ld_ext;
        err_d      = 1'b0;
        state_d    = RESP;
      end
      RMW_READ: begin
        dm_read    = 1'b1;
        dm_address = aligned_q;
        merged_d   = (dm_read_data & ~bit_mask)
                   | (wsh & bit_mask);
        state_d    = WRITE;
      end
      WRITE: begin
        dm_write      = ~reset;
        dm_address    = aligned_q;
        dm_write_data = merged_q;
        rdata_d       = '0;
        err_d         = 1'b0;
        state_d       = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall      = req_valid & ~resp_valid;
  assign resp_rdata = rdata_q;
  assign resp_err   = resp_valid & err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      aligned_q <= '0;
      off_q     <= '0;
      funct3_q  <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      merged_q  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aligned_q <= aligned_d;
      off_q     <= off_d;
      funct3_q  <= funct3_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      merged_q  <= merged_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and random loads/stores
// against a byte-array reference memory.
module tb_mem_access_unit;

  localparam int LIMIT = 64;

  logic        clock = 1'b0;
  logic        reset, req_valid, req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        req_ready, stall, resp_valid, resp_err;
  logic [63:0] resp_rdata, dm_address, dm_write_data, dm_read_data;
  logic        dm_write, dm_read;

  logic [63:0] mem [8];
  logic        mem_init;
  logic [7:0]  ref_mem [LIMIT];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mem_access_unit #(.ADDR_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .stall(stall), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dm_address(dm_address), .dm_write_data(dm_write_data),
    .dm_write(dm_write), .dm_read(dm_read),
    .dm_read_data(dm_read_data)
  );

  assign dm_read_data = mem[dm_address[5:3]];

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 8; i++) mem[i] <= 64'(i + 1);
    end else if (dm_write) begin
      mem[dm_address[5:3]] <= dm_write_data;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    logic [63:0] d;
    for (int w = 0; w < 8; w++) begin
      d = '0;
      for (int b = 0; b < 8; b++)
        d |= 64'(ref_mem[8*w + b]) << (8 * b);
      chk(tag, mem[w], d);
    end
  endtask

  task automatic do_req(input logic w, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd,
                        output logic [63:0] got);
    int sz, exp_lat, exp_rd, exp_wr, n, nrd, nwr;
    bit legal, done;
    logic [63:0] exp_d;
    sz = 1 << f3[1:0];
    legal = (a % 64'(sz) == 0) && ((a / 8) * 8 + 8 <= 64'(LIMIT))
            && !(!w && f3 == 3'b111) && !(w && f3 >= 3'b100);
    exp_d = '0;
    if (legal && !w) begin
      for (int i = 0; i < sz; i++)
        exp_d |= 64'(ref_mem[int'(a) + i]) << (8 * i);
      if (f3 < 3'b100 && sz < 8 && exp_d[8*sz-1])
        exp_d |= ~64'd0 << (8 * sz);
    end
    exp_lat = !legal ? 1 : (!w ? 2 : (sz == 8 ? 2 : 3));
    exp_rd  = (legal && !(w && sz == 8)) ? 1 : 0;
    exp_wr  = (legal && w) ? 1 : 0;
    @(negedge clock);
    chk("ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    @(posedge clock);
    n = 0; nrd = 0; nwr = 0; done = 0; got = '0;
    while (!done && n < 8) begin
      @(negedge clock);
      n++;
      if (dm_read) nrd++;
      if (dm_write) nwr++;
      if (resp_valid) begin
        done = 1;
        got = resp_rdata;
        chk("lat", 64'(n), 64'(exp_lat));
        chk("err", 64'(resp_err), 64'(!legal));
        chk("rdata", resp_rdata, exp_d);
        chk("stall_resp", 64'(stall), 64'd0);
        req_valid = 1'b0;
      end else begin
        chk("stall_busy", 64'(stall), 64'd1);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
      end
    end
    req_valid = 1'b0;
    if (!done) chk("resp_timeout", 64'd0, 64'd1);
    chk("n_read", 64'(nrd), 64'(exp_rd));
    chk("n_write", 64'(nwr), 64'(exp_wr));
    if (legal && w)
      for (int i = 0; i < sz; i++)
        ref_mem[int'(a) + i] = wd[8*i +: 8];
    chk_mem("mem");
  endtask

  initial begin
    logic [63:0] got, a, wd;
    logic [2:0] f3;
    logic w;
    for (int i = 0; i < LIMIT; i++)
      ref_mem[i] = (i % 8 == 0) ? 8'(i / 8 + 1) : 8'd0;
    reset = 1'b1; mem_init = 1'b1; req_valid = 1'b0;
    req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0; mem_init = 1'b0;
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_dm_rw", {62'd0, dm_read, dm_write}, 64'd0);
    chk("rst_dm_addr", dm_address, 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);

    do_req(1'b0, 3'b011, 64'h08, 64'd0, got);
    chk("ld08", got, 64'h2);
    do_req(1'b1, 3'b000, 64'h09, 64'hFF, got);
    do_req(1'b0, 3'b011, 64'h08, 64'd0, got);
    chk("ld08_after_sb", got, 64'h000000000000FF02);
    do_req(1'b0, 3'b000, 64'h09, 64'd0, got);
    chk("lb09", got, 64'hFFFFFFFFFFFFFFFF);
    do_req(1'b0, 3'b100, 64'h09, 64'd0, got);
    chk("lbu09", got, 64'h00000000000000FF);
    @(negedge clock);
    chk("rdata_hold", resp_rdata, 64'h00000000000000FF);
    do_req(1'b1, 3'b011, 64'h38, 64'h1122334455667788, got);
    do_req(1'b0, 3'b011, 64'h38, 64'd0, got);
    chk("ld38", got, 64'h1122334455667788);
    do_req(1'b0, 3'b001, 64'h3E, 64'd0, got);
    chk("lh3e", got, 64'h0000000000001122);
    do_req(1'b0, 3'b010, 64'h0A, 64'd0, got);
    do_req(1'b0, 3'b011, 64'h40, 64'd0, got);

    // reset while the SH sits in WRITE
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001;
    req_addr = 64'h10; req_wdata = 64'hABCD;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    chk("sh_rmw_read", 64'(dm_read), 64'd1);
    @(negedge clock);
    chk("sh_in_write", 64'(dm_write), 64'd1);
    reset = 1'b1;
    #1;
    chk("sh_write_gated", 64'(dm_write), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    chk("post_rst_ready", 64'(req_ready), 64'd1);
    chk("post_rst_resp", 64'(resp_valid), 64'd0);
    chk("post_rst_dw2", mem[2], 64'd3);
    repeat (3) begin
      @(negedge clock);
      chk("post_rst_no_resp", 64'(resp_valid), 64'd0);
    end
    do_req(1'b0, 3'b011, 64'h10, 64'd0, got);
    chk("ld10", got, 64'd3);

    for (int k = 0; k < 200; k++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = w ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
      a  = 64'($urandom_range(0, LIMIT + 7));
      if ($urandom_range(0, 3) != 0)
        a = a & ~64'((1 << f3[1:0]) - 1);
      wd = {$urandom, $urandom};
      do_req(w, f3, a, wd, got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
